// File: rtl/alu_pkg.sv
// Shared opcode, condition and flag definitions for the ALU issue controller.
// Latency: none (definitions only).
// Backpressure: not applicable.
package alu_pkg;

   // ALU opcodes; 1100-1111 are unassigned and treated as illegal
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_MOV  = 4'b0110;
   localparam logic [3:0] OP_MOVN = 4'b0111;
   localparam logic [3:0] OP_LSL  = 4'b1000;
   localparam logic [3:0] OP_LSR  = 4'b1001;
   localparam logic [3:0] OP_CMP  = 4'b1010;
   localparam logic [3:0] OP_SETF = 4'b1011;

   // condition codes
   localparam logic [3:0] CC_EQ = 4'b0000;
   localparam logic [3:0] CC_NE = 4'b0001;
   localparam logic [3:0] CC_CS = 4'b0010;
   localparam logic [3:0] CC_CC = 4'b0011;
   localparam logic [3:0] CC_MI = 4'b0100;
   localparam logic [3:0] CC_PL = 4'b0101;
   localparam logic [3:0] CC_VS = 4'b0110;
   localparam logic [3:0] CC_VC = 4'b0111;
   localparam logic [3:0] CC_HI = 4'b1000;
   localparam logic [3:0] CC_LS = 4'b1001;
   localparam logic [3:0] CC_GE = 4'b1010;
   localparam logic [3:0] CC_LT = 4'b1011;
   localparam logic [3:0] CC_GT = 4'b1100;
   localparam logic [3:0] CC_LE = 4'b1101;
   localparam logic [3:0] CC_AL = 4'b1110;
   localparam logic [3:0] CC_NV = 4'b1111;

   // flag bit positions within {N,Z,C,V}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   function automatic logic is_legal(input logic [3:0] op);
      return (op[3:2] != 2'b11);
   endfunction

   function automatic logic is_mov(input logic [3:0] op);
      return (op == OP_MOV) || (op == OP_MOVN);
   endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Evaluates a 4-bit condition code against the {N,Z,C,V} flags.
// Latency: combinational.
// Backpressure: not applicable.
module alu_cond_eval
   import alu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;
   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // decode the condition code into a single pass bit
   always_comb begin
      pass = 1'b0;
      case (cond)
         CC_EQ: pass = z;
         CC_NE: pass = !z;
         CC_CS: pass = c;
         CC_CC: pass = !c;
         CC_MI: pass = n;
         CC_PL: pass = !n;
         CC_VS: pass = v;
         CC_VC: pass = !v;
         CC_HI: pass = c && !z;
         CC_LS: pass = !c || z;
         CC_GE: pass = (n == v);
         CC_LT: pass = (n != v);
         CC_GT: pass = !z && (n == v);
         CC_LE: pass = z || (n != v);
         CC_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to the ALU, waits its latency, writes back and updates flags.
// Latency: accept to wb_valid = ALU_LAT+1 (MUL_LAT+1 for MUL, 2 for cond-fail/illegal).
// Backpressure: in_ready is low from accept until the cycle after the writeback beat.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_opcode,
   input  logic [3:0]  in_cond,
   input  logic        in_s,
   input  logic [15:0] in_iv,
   output logic [3:0]  alu_opcode,
   output logic        alu_s,
   output logic [15:0] alu_iv,
   output logic [3:0]  alu_flag,
   input  logic [31:0] alu_result,
   input  logic [3:0]  alu_new_flag,
   output logic        wb_valid,
   output logic        wb_en,
   output logic [31:0] wb_data,
   output logic [3:0]  flags,
   output logic        illegal
);

   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
   localparam logic [3:0] ALU_CNT = 4'(ALU_LAT);

   state_t     state;
   logic [3:0] cnt;
   logic       pass_q;
   logic       cond_pass;
   logic       legal;
   logic       do_wr;
   logic       do_flag;

   alu_cond_eval u_cond (
      .cond  (in_cond),
      .flags (flags),
      .pass  (cond_pass)
   );

   assign alu_flag = flags;
   assign legal    = is_legal(alu_opcode);
   assign do_wr    = pass_q && legal;
   assign do_flag  = do_wr && !is_mov(alu_opcode) && (alu_s || (alu_opcode == OP_SETF));

   // sequencing FSM with registered handshake, ALU drive and writeback outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         pass_q     <= 1'b0;
         in_ready   <= 1'b1;
         alu_opcode <= 4'd0;
         alu_s      <= 1'b0;
         alu_iv     <= 16'd0;
         wb_valid   <= 1'b0;
         wb_en      <= 1'b0;
         wb_data    <= 32'd0;
         flags      <= 4'd0;
         illegal    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               wb_valid <= 1'b0;
               wb_en    <= 1'b0;
               illegal  <= 1'b0;
               if (in_valid && in_ready) begin
                  alu_opcode <= in_opcode;
                  alu_s      <= in_s;
                  alu_iv     <= in_iv;
                  pass_q     <= cond_pass;
                  if (in_opcode == OP_MUL)
                     cnt <= MUL_CNT;
                  else if (is_legal(in_opcode))
                     cnt <= ALU_CNT;
                  else
                     cnt <= 4'd0;
                  in_ready <= 1'b0;
                  state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // skipped or finished instructions leave after one EXEC cycle
               if (!pass_q || !legal || (cnt <= 4'd1)) begin
                  wb_valid <= 1'b1;
                  wb_en    <= do_wr;
                  illegal  <= !legal;
                  if (do_wr)
                     wb_data <= alu_result;
                  if (do_flag)
                     flags <= alu_new_flag;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_DONE: begin
               wb_valid <= 1'b0;
               wb_en    <= 1'b0;
               illegal  <= 1'b0;
               in_ready <= 1'b1;
               state    <= ST_IDLE;
            end
            default: begin
               in_ready <= 1'b1;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
